// File: rtl/mdr_div_iter.sv
// Iterative restoring divider: one quotient bit per clock, exposing each step's
// shifted partial remainder and trial difference to a downstream remainder register.
module mdr_div_iter #(
    parameter int DW  = 16,
    parameter int DW2 = 2 * DW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [DW-1:0]  i_dividend,
    input  logic [DW-1:0]  i_divisor,
    output logic [DW2-1:0] o_result,
    output logic [DW2-1:0] o_remainder,
    output logic           o_flag,
    output logic [DW-1:0]  o_quotient,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [DW2-1:0]  r_rem;
    logic [DW-1:0]   r_quo;
    logic [DW-1:0]   r_dvs;
    logic [CW-1:0]   r_cnt;
    logic            r_dbz;

    logic [DW2-1:0]  w_shifted;
    logic [DW2-1:0]  w_trial;
    logic            w_neg;
    logic            w_unused_rem_msb;

    // Step datapath: shift in the next dividend bit, then trial-subtract the divisor.
    always_comb begin
        w_shifted        = {r_rem[DW2-2:0], r_quo[DW-1]};
        w_trial          = w_shifted - {{(DW2-DW){1'b0}}, r_dvs};
        w_neg            = w_trial[DW2-1];
        w_unused_rem_msb = r_rem[DW2-1];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= {DW2{1'b0}};
            r_quo   <= {DW{1'b0}};
            r_dvs   <= {DW{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        if (i_divisor != {DW{1'b0}}) begin
                            r_rem   <= {DW2{1'b0}};
                            r_quo   <= i_dividend;
                            r_dvs   <= i_divisor;
                            r_cnt   <= {CW{1'b0}};
                            r_dbz   <= 1'b0;
                            r_state <= S_RUN;
                        end else begin
                            // Zero divisor: saturate the quotient and finish at once.
                            r_quo   <= {DW{1'b1}};
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_neg) begin
                        r_rem <= w_shifted;
                        r_quo <= {r_quo[DW-2:0], 1'b0};
                    end else begin
                        r_rem <= w_trial;
                        r_quo <= {r_quo[DW-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(DW - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_remainder   = w_shifted;
    assign o_result      = w_trial;
    assign o_flag        = (r_state == S_RUN);
    assign o_busy        = (r_state == S_RUN);
    assign o_done        = (r_state == S_DONE);
    assign o_quotient    = r_quo;
    assign o_div_by_zero = r_dbz;

endmodule
